// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared message layout, slot-state encoding and default parameters for the L2 pipe arbiter.
package l2_arb_pkg;
  localparam int TAG_W_DEF      = 26;
  localparam int DATA_W_DEF     = 64;
  localparam int MAX_OUT_DEF    = 4;
  localparam int STARVE_LIM_DEF = 4;
  localparam int TYPE_W         = 8;
  localparam int SRC_W          = 6;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
  typedef struct packed {
    logic [TYPE_W-1:0]     mtype;
    logic [SRC_W-1:0]      source;
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } msg_t;
endpackage

// File: rtl/l2_pipe_arb_if.sv
// l2_pipe_arb_if: request/response channels, pipeline port, commit and status of the L2 pipe arbiter.
interface l2_pipe_arb_if
  import l2_arb_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              msg1_valid, msg1_ready;
  logic [TYPE_W-1:0] msg1_type;
  logic [SRC_W-1:0]  msg1_source;
  logic [TAG_W-1:0]  msg1_tag;
  logic [DATA_W-1:0] msg1_data;
  logic              msg3_valid, msg3_ready;
  logic [TYPE_W-1:0] msg3_type;
  logic [SRC_W-1:0]  msg3_source;
  logic [TAG_W-1:0]  msg3_tag;
  logic [DATA_W-1:0] msg3_data;
  logic              pipe_valid, pipe_ready, pipe_sel;
  logic [TYPE_W-1:0] pipe_type;
  logic [SRC_W-1:0]  pipe_source;
  logic [TAG_W-1:0]  pipe_tag;
  logic [DATA_W-1:0] pipe_data;
  logic              commit, err;
  logic [3:0]        outstanding;
  modport slave (
    input  msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
    input  msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
    input  pipe_ready, commit,
    output msg1_ready, msg3_ready,
    output pipe_valid, pipe_sel, pipe_type, pipe_source, pipe_tag, pipe_data,
    output outstanding, err
  );
  modport master (
    output msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
    output msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
    output pipe_ready, commit,
    input  msg1_ready, msg3_ready,
    input  pipe_valid, pipe_sel, pipe_type, pipe_source, pipe_tag, pipe_data,
    input  outstanding, err
  );
endinterface

// File: rtl/l2_pipe_slot.sv
// l2_pipe_slot: single registered output slot with EMPTY/FULL control toward the L2 pipeline.
module l2_pipe_slot
  import l2_arb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         grant_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         accept_o,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  slot_state_e  state_q, state_d;
  logic [W-1:0] data_q, data_d;
  always_ff @(posedge clk) begin
    state_q <= rst ? EMPTY : state_d;
    data_q  <= rst ? '0 : data_d;
  end
  always_comb begin
    state_d = grant_i ? FULL : (state_q == FULL && !ready_i) ? FULL : EMPTY;
    data_d  = grant_i ? data_i : data_q;
  end
  // accept lets a new grant land in the same cycle the held entry drains
  always_comb begin
    accept_o = state_q == EMPTY || ready_i;
    valid_o  = state_q == FULL;
    data_o   = data_q;
  end
endmodule

// File: rtl/l2_pipe_arb.sv
// l2_pipe_arb: arbitrates request (msg1) and response (msg3) channels into the L2 pipeline with request credits.
// Define L2_PIPE_ARB_FAIRNESS_EN to let a starved request win after STARVE_LIM consecutive response grants.
module l2_pipe_arb
  import l2_arb_pkg::*;
#(
  parameter int TAG_W      = TAG_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_OUT    = MAX_OUT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input logic           clk,
  input logic           rst,
  l2_pipe_arb_if.slave  bus
);
  localparam int         W     = 1 + TYPE_W + SRC_W + TAG_W + DATA_W;
  localparam logic [3:0] MAX_C = 4'(MAX_OUT);
  logic [3:0]   out_q, out_d;
  logic         err_q, err_d;
  logic         accept, elig1, force1, g1, g3, slot_valid;
  logic [W-1:0] sel_msg, slot_data;
  // credits come from the registered count only, so a commit frees nothing until the next cycle
  assign elig1 = bus.msg1_valid && out_q < MAX_C;
`ifdef L2_PIPE_ARB_FAIRNESS_EN
  localparam logic [3:0] LIM_C = 4'(STARVE_LIM);
  logic [3:0] starve_q, starve_d;
  assign force1 = elig1 && starve_q == LIM_C;
  always_comb starve_d = g1 ? 4'd0 : (g3 && elig1) ? starve_q + 4'd1 : starve_q;
  always_ff @(posedge clk) starve_q <= rst ? 4'd0 : starve_d;
`else
  logic [3:0] unused_starve;
  assign unused_starve = 4'(STARVE_LIM);
  assign force1 = 1'b0;
`endif
  always_comb begin
    g3 = !rst && accept && bus.msg3_valid && !force1;
    g1 = !rst && accept && elig1 && !g3;
  end
  always_comb begin
    out_d = out_q + {3'd0, g1} - {3'd0, bus.commit && (out_q != 4'd0 || g1)};
    err_d = err_q || (bus.commit && out_q == 4'd0 && !g1);
  end
  always_ff @(posedge clk) begin
    out_q <= rst ? 4'd0 : out_d;
    err_q <= rst ? 1'b0 : err_d;
  end
  assign sel_msg = g3 ? {1'b1, bus.msg3_type, bus.msg3_source, bus.msg3_tag, bus.msg3_data}
                      : {1'b0, bus.msg1_type, bus.msg1_source, bus.msg1_tag, bus.msg1_data};
  l2_pipe_slot #(.W(W)) u_slot (
    .clk      (clk),
    .rst      (rst),
    .grant_i  (g1 || g3),
    .data_i   (sel_msg),
    .ready_i  (bus.pipe_ready),
    .accept_o (accept),
    .valid_o  (slot_valid),
    .data_o   (slot_data)
  );
  assign bus.msg1_ready  = g1;
  assign bus.msg3_ready  = g3;
  assign bus.pipe_valid  = slot_valid;
  assign {bus.pipe_sel, bus.pipe_type, bus.pipe_source, bus.pipe_tag, bus.pipe_data} = slot_data;
  assign bus.outstanding = out_q;
  assign bus.err         = err_q;
endmodule

// File: doc/l2_pipe_arb.md
L2_PIPE_ARB -- requirements
Module: l2_pipe_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 26, cache-line tag width.
REQ-002 SHALL have parameter DATA_W, default 64, message data width.
REQ-003 SHALL have parameter MAX_OUT, default 4, maximum outstanding request-channel grants awaiting commit (range 1..15).
REQ-004 SHALL have parameter STARVE_LIM, default 4, consecutive response grants tolerated while a request waits.
REQ-005 SHALL have one clock; reset is synchronous and active-high. Ports below are listed as name, direction, width and meaning.
REQ-006 clk  in  1  sole clock, all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 msg1_valid/msg1_ready  in/out  1/1  request channel handshake.
REQ-009 msg1_type/msg1_source/msg1_tag/msg1_data  in  8/6/TAG_W/DATA_W  request payload.
REQ-010 msg3_valid/msg3_ready  in/out  1/1  response channel handshake.
REQ-011 msg3_type/msg3_source/msg3_tag/msg3_data  in  8/6/TAG_W/DATA_W  response payload.
REQ-012 pipe_valid/pipe_ready  out/in  1/1  L2 pipeline input handshake; pipe_ready low means the pipeline is stalled.
REQ-013 pipe_type/pipe_source/pipe_tag/pipe_data/pipe_sel  out  8/6/TAG_W/DATA_W/1  registered payload; pipe_sel 0=msg1, 1=msg3.
REQ-014 commit  in  1  one pulse per request-channel message retired by the pipeline.
REQ-015 outstanding  out  4  current outstanding request count.
REQ-016 err  out  1  sticky protocol error flag.

Function
REQ-017 Output slot FSM SHALL have states EMPTY and FULL; EMPTY->FULL on grant; FULL->EMPTY on pipe_ready with no new grant; FULL->FULL on pipe_ready with grant, or when pipe_ready is low.
REQ-018 A grant SHALL be possible only when the slot is EMPTY or pipe_ready=1 (slot drains the same cycle).
REQ-019 msg1 SHALL be eligible only when outstanding < MAX_OUT.
REQ-020 Base priority SHALL be msg3 over msg1, so responses are never blocked by requests.
REQ-021 msg1_ready and msg3_ready SHALL be combinational, at most one high per cycle, and each high only for the channel granted that cycle.
REQ-022 A granted payload SHALL appear on pipe_* the cycle after the handshake (1-cycle latency) and SHALL hold stable while pipe_valid=1 and pipe_ready=0.
REQ-023 outstanding SHALL increment on msg1 grant and decrement on commit; simultaneous grant and commit SHALL leave it unchanged.
REQ-024 commit with outstanding=0 and no simultaneous msg1 grant SHALL be ignored and SHALL set err.
REQ-025 msg1 eligibility SHALL use the registered outstanding count, so a commit cannot free a credit in the same cycle it arrives.

Reset
REQ-026 On rst: slot EMPTY, pipe_valid=0, pipe_* payload=0, pipe_sel=0, outstanding=0, err=0, starvation counter=0.
REQ-027 Reset mid-operation SHALL discard the held slot contents and all credits without emitting pipe_valid on the following cycle.
REQ-028 msg1_ready and msg3_ready SHALL be 0 during any cycle in which rst=1.

Configuration
REQ-029 Macro L2_PIPE_ARB_FAIRNESS_EN defined: a 4-bit starvation counter SHALL increment on each msg3 grant while msg1 is valid and eligible, and SHALL clear on any msg1 grant.
REQ-030 With L2_PIPE_ARB_FAIRNESS_EN defined: when the counter equals STARVE_LIM, the next grant SHALL go to msg1 even if msg3 is valid.
REQ-031 Macro undefined: strict msg3 priority; no counter is present.

Structure
REQ-032 Shared package l2_arb_pkg SHALL hold the message struct typedef (type, source, tag, data), the slot-state enum, and the default parameter constants.
REQ-033 The output register and EMPTY/FULL FSM SHALL be a sub-module l2_pipe_slot; grant logic and credit counter SHALL live in l2_pipe_arb.

Verification
REQ-034 Bench SHALL drive msg1_valid only with tag 0x155, pipe_ready=1 -> pipe_valid next cycle, pipe_tag=0x155, pipe_sel=0, outstanding=1.
REQ-035 Bench SHALL drive msg1 and msg3 valid together with fairness undefined -> msg3 is granted every cycle and msg1_ready stays 0.
REQ-036 Bench SHALL drive msg1 and msg3 valid continuously with fairness defined and STARVE_LIM=4 -> grant sequence msg3, msg3, msg3, msg3, msg1, repeating.
REQ-037 Bench SHALL issue 4 msg1 grants with no commit -> outstanding=4 and msg1_ready=0; one commit pulse -> a msg1 grant occurs the following cycle.
REQ-038 Bench SHALL hold pipe_ready=0 for 3 cycles with the slot FULL -> pipe_* stable, both ready outputs 0; then pipe_ready=1 with a new msg3 -> back-to-back transfer.
REQ-039 Bench SHALL pulse commit with outstanding=0 -> err=1 and it stays 1 until rst; rst asserted with the slot FULL -> pipe_valid=0 the next cycle.
